// File: rtl/fetch_stage.sv
// fetch_stage: IF stage plus IF/ID pipeline register of the 5-stage RISC-V core.
//
// Holds the PC, drives the instruction-memory address and latches the fetched
// instruction/PC into the ID-side registers. Load-use stalls arrive from the
// hazard unit (PCWrite / IF_ID_Write); redirects arrive from branch resolution
// (branch_taken / branch_target) and flush the IF/ID register.
//
// Ports:
//   clk            core clock, rising edge
//   rst            synchronous reset, active-high (overrides everything)
//   enable         global pipeline enable; 0 freezes all state
//   PCWrite        0 holds the PC (stall)
//   IF_ID_Write    0 holds the IF/ID register (stall)
//   branch_taken   redirect this cycle; flushes IF/ID
//   branch_target  redirect address (passed through unaligned)
//   instr_addr     instruction-memory address, direct wire from the PC register
//   instr_rdata    instruction-memory read data for instr_addr
//   pc_ID          PC of the instruction in ID
//   instruction_ID instruction in ID (NOP_INSTR when bubble)
//   valid_ID       1 = real instruction, 0 = bubble
//
// Optional build macro FETCH_STALL_CNT_EN adds:
//   stall_cycles   count of edges where IF/ID was held by a stall
//   flush_count    count of edges where a redirect flushed IF/ID

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_rdata,
  output logic [31:0] pc_ID,
  output logic [31:0] instruction_ID,
  output logic        valid_ID
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_id_q, pc_id_d;
  logic [XLEN-1:0] instr_id_q, instr_id_d;
  logic            valid_id_q, valid_id_d;

`ifdef FETCH_STALL_CNT_EN
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  logic [XLEN-1:0] flush_cnt_q, flush_cnt_d;
`endif

  // Next-state: flush beats stall because the branch is older than the stalled instruction.
  always_comb begin
    pc_d       = pc_q;
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    valid_id_d = valid_id_q;
`ifdef FETCH_STALL_CNT_EN
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
`endif
    if (enable) begin
      if (branch_taken) begin
        pc_d       = branch_target;
        pc_id_d    = '0;
        instr_id_d = NOP_INSTR;
        valid_id_d = 1'b0;
`ifdef FETCH_STALL_CNT_EN
        flush_cnt_d = flush_cnt_q + XLEN'(1);
`endif
      end else begin
        // PC and IF/ID enables are independent; PC wraps modulo 2^32.
        if (PCWrite) begin
          pc_d = pc_q + XLEN'(4);
        end
        if (IF_ID_Write) begin
          pc_id_d    = pc_q;
          instr_id_d = instr_rdata;
          valid_id_d = 1'b1;
        end
`ifdef FETCH_STALL_CNT_EN
        else begin
          stall_cnt_d = stall_cnt_q + XLEN'(1);
        end
`endif
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pc_id_q    <= '0;
      instr_id_q <= NOP_INSTR;
      valid_id_q <= 1'b0;
`ifdef FETCH_STALL_CNT_EN
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
`endif
    end else begin
      pc_q       <= pc_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
      valid_id_q <= valid_id_d;
`ifdef FETCH_STALL_CNT_EN
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
`endif
    end
  end

  assign instr_addr     = pc_q;
  assign pc_ID          = pc_id_q;
  assign instruction_ID = instr_id_q;
  assign valid_ID       = valid_id_q;
`ifdef FETCH_STALL_CNT_EN
  assign stall_cycles   = stall_cnt_q;
  assign flush_count    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory model: mem[a] = a | 0x13.

module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_addr;
  logic [31:0] instr_rdata;
  logic [31:0] pc_ID;
  logic [31:0] instruction_ID;
  logic        valid_ID;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int total;
  int bad;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .instr_addr     (instr_addr),
    .instr_rdata    (instr_rdata),
    .pc_ID          (pc_ID),
    .instruction_ID (instruction_ID),
    .valid_ID       (valid_ID)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`endif
  );

  assign instr_rdata = instr_addr | 32'h0000_0013;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h0000_0400;
    step(); step();
    total++; if (instr_addr !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", instr_addr, 32'h0); end
    total++; if (pc_ID !== 32'h0) begin bad++; $display("FAIL reset_pc_id got=%h exp=%h", pc_ID, 32'h0); end
    total++; if (instruction_ID !== 32'h13) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instruction_ID, 32'h13); end
    total++; if (valid_ID !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_ID); end
`ifdef FETCH_STALL_CNT_EN
    total++; if (stall_cycles !== 32'h0 || flush_count !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h/%h exp=0/0", stall_cycles, flush_count); end
`endif
    branch_taken = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    logic [31:0] e_pc;
    total++; if (instr_addr !== 32'h0) begin bad++; $display("FAIL run_c0_addr got=%h exp=%h", instr_addr, 32'h0); end
    for (int k = 1; k <= 4; k++) begin
      step();
      e_pc = 32'(4 * k);
      total++; if (instr_addr !== e_pc) begin bad++; $display("FAIL run_addr k=%0d got=%h exp=%h", k, instr_addr, e_pc); end
      total++; if (pc_ID !== e_pc - 32'd4) begin bad++; $display("FAIL run_pc_id k=%0d got=%h exp=%h", k, pc_ID, e_pc - 32'd4); end
      total++; if (instruction_ID !== ((e_pc - 32'd4) | 32'h13)) begin bad++; $display("FAIL run_instr k=%0d got=%h exp=%h", k, instruction_ID, (e_pc - 32'd4) | 32'h13); end
      total++; if (valid_ID !== 1'b1) begin bad++; $display("FAIL run_valid k=%0d got=%b exp=1", k, valid_ID); end
    end
  endtask

  task automatic test_stall();
    PCWrite = 1'b0; IF_ID_Write = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (instr_addr !== 32'h10) begin bad++; $display("FAIL stall_pc k=%0d got=%h exp=%h", k, instr_addr, 32'h10); end
      total++; if (pc_ID !== 32'h0C || instruction_ID !== 32'h1F) begin bad++; $display("FAIL stall_id k=%0d got=%h/%h exp=%h/%h", k, pc_ID, instruction_ID, 32'h0C, 32'h1F); end
    end
    PCWrite = 1'b1; IF_ID_Write = 1'b1;
    step();
    total++; if (pc_ID !== 32'h10 || instr_addr !== 32'h14) begin bad++; $display("FAIL stall_rel1 got=%h/%h exp=%h/%h", pc_ID, instr_addr, 32'h10, 32'h14); end
    step();
    total++; if (pc_ID !== 32'h14 || instruction_ID !== 32'h17) begin bad++; $display("FAIL stall_rel2 got=%h/%h exp=%h/%h", pc_ID, instruction_ID, 32'h14, 32'h17); end
`ifdef FETCH_STALL_CNT_EN
    total++; if (stall_cycles !== 32'd2) begin bad++; $display("FAIL stall_cnt got=%0d exp=2", stall_cycles); end
`endif
  endtask

  task automatic test_flush();
    branch_taken = 1'b1; branch_target = 32'h100; PCWrite = 1'b0; IF_ID_Write = 1'b0;
    step();
    total++; if (instr_addr !== 32'h100) begin bad++; $display("FAIL flush_pc got=%h exp=%h", instr_addr, 32'h100); end
    total++; if (instruction_ID !== 32'h13 || valid_ID !== 1'b0 || pc_ID !== 32'h0) begin bad++; $display("FAIL flush_id got=%h/%b/%h exp=%h/0/0", instruction_ID, valid_ID, pc_ID, 32'h13); end
    branch_taken = 1'b0; PCWrite = 1'b1; IF_ID_Write = 1'b1;
    step();
    total++; if (pc_ID !== 32'h100 || valid_ID !== 1'b1 || instruction_ID !== 32'h113) begin bad++; $display("FAIL flush_next got=%h/%b/%h exp=%h/1/%h", pc_ID, valid_ID, instruction_ID, 32'h100, 32'h113); end
    total++; if (instr_addr !== 32'h104) begin bad++; $display("FAIL flush_next_pc got=%h exp=%h", instr_addr, 32'h104); end
`ifdef FETCH_STALL_CNT_EN
    total++; if (flush_count !== 32'd1 || stall_cycles !== 32'd2) begin bad++; $display("FAIL flush_cnt got=%0d/%0d exp=1/2", flush_count, stall_cycles); end
`endif
  endtask

  task automatic test_enable_hold();
    enable = 1'b0; branch_taken = 1'b1; branch_target = 32'h800; IF_ID_Write = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (instr_addr !== 32'h104 || pc_ID !== 32'h100 || instruction_ID !== 32'h113 || valid_ID !== 1'b1) begin
        bad++; $display("FAIL hold k=%0d got=%h/%h/%h/%b exp=%h/%h/%h/1", k, instr_addr, pc_ID, instruction_ID, valid_ID, 32'h104, 32'h100, 32'h113);
      end
`ifdef FETCH_STALL_CNT_EN
      total++; if (flush_count !== 32'd1 || stall_cycles !== 32'd2) begin bad++; $display("FAIL hold_cnt k=%0d got=%0d/%0d exp=1/2", k, flush_count, stall_cycles); end
`endif
    end
    enable = 1'b1; branch_taken = 1'b0; IF_ID_Write = 1'b1;
  endtask

  task automatic test_wrap_mixed();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    total++; if (instr_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup got=%h exp=%h", instr_addr, 32'hFFFF_FFFC); end
    branch_taken = 1'b0;
    step();
    total++; if (instr_addr !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", instr_addr, 32'h0); end
    total++; if (pc_ID !== 32'hFFFF_FFFC || instruction_ID !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_id got=%h/%h exp=%h/%h", pc_ID, instruction_ID, 32'hFFFF_FFFC, 32'hFFFF_FFFF); end
    // PC advances while IF/ID holds.
    IF_ID_Write = 1'b0;
    step();
    total++; if (instr_addr !== 32'h4 || pc_ID !== 32'hFFFF_FFFC || valid_ID !== 1'b1) begin bad++; $display("FAIL mixed got=%h/%h/%b exp=%h/%h/1", instr_addr, pc_ID, valid_ID, 32'h4, 32'hFFFF_FFFC); end
`ifdef FETCH_STALL_CNT_EN
    total++; if (flush_count !== 32'd2 || stall_cycles !== 32'd3) begin bad++; $display("FAIL mixed_cnt got=%0d/%0d exp=2/3", flush_count, stall_cycles); end
`endif
    IF_ID_Write = 1'b1; branch_taken = 1'b1; branch_target = 32'h203;
    step();
    total++; if (instr_addr !== 32'h203) begin bad++; $display("FAIL misaligned got=%h exp=%h", instr_addr, 32'h203); end
    branch_taken = 1'b0;
  endtask

  task automatic test_reset_in_stall();
    PCWrite = 1'b0; IF_ID_Write = 1'b0;
    step();
    rst = 1'b1;
    step();
    total++; if (instr_addr !== 32'h0 || instruction_ID !== 32'h13 || valid_ID !== 1'b0 || pc_ID !== 32'h0) begin
      bad++; $display("FAIL rst_stall got=%h/%h/%b/%h exp=0/%h/0/0", instr_addr, instruction_ID, valid_ID, pc_ID, 32'h13);
    end
`ifdef FETCH_STALL_CNT_EN
    total++; if (stall_cycles !== 32'h0 || flush_count !== 32'h0) begin bad++; $display("FAIL rst_stall_cnt got=%0d/%0d exp=0/0", stall_cycles, flush_count); end
`endif
    rst = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; enable = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1;
    branch_taken = 1'b0; branch_target = 32'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_flush();
    test_enable_hold();
    test_wrap_mixed();
    test_reset_in_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RISC-V core.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched instruction and PC into the ID-side registers.
- Consumes PCWrite / IF_ID_Write from the hazard unit (load-use stall) and branch_taken / branch_target from the branch-resolution stage (flush).
- Its instruction_ID output is the ID-stage instruction seen by the hazard unit and decoder.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) inserted on flush/reset.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  global pipeline enable; 0 freezes all state.
- PCWrite  input  1  from hazard unit; 0 holds the PC.
- IF_ID_Write  input  1  from hazard unit; 0 holds the IF/ID register.
- branch_taken  input  1  branch/jump resolved taken this cycle.
- branch_target  input  32  redirect address, valid with branch_taken.
- instr_addr  output  32  instruction-memory address (= current PC, combinational from PC register).
- instr_rdata  input  32  instruction-memory read data, combinational for instr_addr.
- pc_ID  output  32  PC of the instruction in ID.
- instruction_ID  output  32  instruction in ID.
- valid_ID  output  1  1 = instruction_ID is a real fetched instruction; 0 = bubble.

Behaviour:
- Reset (rst=1 at a clk edge) overrides enable and all inputs:
  - PC <= RESET_PC.
  - pc_ID <= 0.
  - instruction_ID <= NOP_INSTR.
  - valid_ID <= 0.
- enable=0 (and rst=0): PC, pc_ID, instruction_ID and valid_ID all hold.
- With enable=1, priority per edge is rst > branch_taken > stall > normal.
- Flush (branch_taken=1):
  - PC <= branch_target, regardless of PCWrite.
  - instruction_ID <= NOP_INSTR, valid_ID <= 0, pc_ID <= 0, regardless of IF_ID_Write.
  - A concurrent stall is discarded: the branch is older than the stalled instruction.
- PC update without flush:
  - PCWrite=1: PC <= PC + 4, 32-bit modulo; 0xFFFF_FFFC wraps to 0x0000_0000.
  - PCWrite=0: PC holds.
- IF/ID update without flush:
  - IF_ID_Write=1: instruction_ID <= instr_rdata, pc_ID <= PC, valid_ID <= 1.
  - IF_ID_Write=0: all three hold.
- PCWrite and IF_ID_Write are honoured independently. The mixed case PCWrite=1 with IF_ID_Write=0 is legal: the PC advances and the IF/ID register holds.
- Latency:
  - instr_addr reflects a new PC in the same cycle it is registered.
  - The instruction at that address appears on instruction_ID one edge later.
- First fetch after reset deassert:
  - Cycle 0: instr_addr=RESET_PC.
  - Cycle 1: instruction_ID = mem[RESET_PC], valid_ID=1, pc_ID=RESET_PC.
- Misaligned branch_target (bits[1:0]≠0) is passed through unchanged; alignment checking is not this block's job.
- Outputs are pure register outputs except instr_addr, which is a direct wire from the PC register.

Optional Feature:
- Macro: FETCH_STALL_CNT_EN.
- When defined, two extra output ports are added, both cleared by rst and frozen when enable=0:
  - stall_cycles (32 bits): increments each edge with enable=1, rst=0, branch_taken=0 and IF_ID_Write=0.
  - flush_count (32 bits): increments each edge with enable=1, rst=0 and branch_taken=1.
- Both counters wrap modulo 2^32.
- When not defined, neither port nor the counter logic exists, and the remaining behaviour is unchanged.

Test Plan:
- Reset then free-run, mem[a]=a|0x13: after rst low, instr_addr 0,4,8,… per cycle; instruction_ID = mem[pc_ID] with a one-cycle lag; valid_ID=1 from cycle 1.
- PCWrite=0 and IF_ID_Write=0 for 2 cycles while PC=0x10, pc_ID=0x0C: PC stays 0x10 and pc_ID stays 0x0C for 2 cycles; on release, pc_ID=0x10, then 0x14. With FETCH_STALL_CNT_EN, stall_cycles=2.
- branch_taken=1, branch_target=0x100, with PCWrite=0 and IF_ID_Write=0 in the same cycle: next cycle PC=0x100, instruction_ID=0x00000013, valid_ID=0; the cycle after, pc_ID=0x100, valid_ID=1. With FETCH_STALL_CNT_EN, flush_count=1 and stall_cycles is unchanged.
- enable=0 for 3 cycles mid-run: every output is bit-identical across the window, including counters.
- PC=0xFFFF_FFFC with PCWrite=1 → next PC=0x0000_0000; rst=1 asserted during a stall → PC=RESET_PC, instruction_ID=NOP_INSTR, valid_ID=0 the next edge.
